// File: rtl/multimode_wave_gen.sv
// multimode_wave_gen: phase-accumulator generator for saw/triangle/rhomboid/square waves
// with a pending configuration that is swapped in only at a period boundary.
module multimode_wave_gen #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  wave_out,
  output logic              sample_valid,
  output logic              period_start,
  output logic              cfg_pending
);
  typedef enum logic [1:0] {IDLE, RUN, RUN_PEND} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] ph, step_act, pend_step, base, wave_nx;
  logic [WIDTH:0]   sum;
  logic [1:0]       mode_act, pend_mode;
  logic             toggle, apply;
  always_comb begin
    sum      = {1'b0, ph} + {1'b0, step_act};
    apply    = cfg_pending && (state == IDLE || step_act == '0 || (en && sum[WIDTH]));
    base     = ph[WIDTH-1] ? ~ph : ph;
    wave_nx  = mode_act == 2'd0 ? ph :
               mode_act == 2'd1 ? (ph[WIDTH-1] ? ~{ph[WIDTH-2:0], 1'b0} : {ph[WIDTH-2:0], 1'b0}) :
               mode_act == 2'd2 ? (toggle ? base : ~base + 1'b1) :
               {WIDTH{ph[WIDTH-1]}};
    state_nx = !en ? IDLE : (load || (cfg_pending && !apply)) ? RUN_PEND : RUN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ph           <= '0;
      wave_out     <= '0;
      sample_valid <= 1'b0;
      period_start <= 1'b0;
      cfg_pending  <= 1'b0;
      toggle       <= 1'b1;
      mode_act     <= 2'd0;
      step_act     <= WIDTH'(1);
      pend_mode    <= 2'd0;
      pend_step    <= '0;
    end else begin
      state        <= state_nx;
      sample_valid <= en;
      period_start <= en && ph < step_act;
      cfg_pending  <= load || (cfg_pending && !apply);
      if (load) begin
        pend_mode <= mode;
        pend_step <= WIDTH'(step);
      end
      if (en) begin
        wave_out <= wave_nx;
        ph       <= sum[WIDTH-1:0];
        toggle   <= ~toggle;
      end
      // apply overrides the phase advance; the sample above still used the old config
      if (apply) begin
        mode_act <= pend_mode;
        step_act <= pend_step;
        ph       <= '0;
        toggle   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multimode_wave_gen.sv
// tb_multimode_wave_gen: directed stimulus with an arithmetic reference model checked every
// cycle, plus literal sample sequences that pin the model.
module tb_multimode_wave_gen;
  logic       clk, rst, en, load;
  logic [1:0] mode;
  logic [7:0] step, wave_out;
  logic       sample_valid, period_start, cfg_pending;
  int vec = 0, errs = 0;
  int m_ph, m_tog, m_mode, m_step, p_mode, p_step, m_pend, m_idle, m_wave, m_sv, m_ps;
  int seq[$];

  multimode_wave_gen #(.WIDTH(8), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode), .step(step),
    .wave_out(wave_out), .sample_valid(sample_valid), .period_start(period_start),
    .cfg_pending(cfg_pending)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int wave_of(int ph, int md, int tog);
    int dbl, base;
    dbl  = (2 * ph) % 256;
    base = ph < 128 ? ph : 255 - ph;
    case (md)
      0: return ph;
      1: return ph < 128 ? dbl : 255 - dbl;
      2: return tog ? base : (256 - base) % 256;
      default: return ph < 128 ? 0 : 255;
    endcase
  endfunction

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference model: one sample per enabled cycle, config swapped at a wrap, in idle, or at step 0
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = 0; m_tog = 1; m_mode = 0; m_step = 1; p_mode = 0; p_step = 0;
      m_pend = 0; m_idle = 1; m_wave = 0; m_sv = 0; m_ps = 0;
    end else begin
      automatic int app = m_pend && (m_idle || m_step == 0 || (en && m_ph + m_step >= 256));
      m_ps = 0;
      if (en) begin
        m_wave = wave_of(m_ph, m_mode, m_tog);
        m_ps   = m_ph < m_step;
        m_ph   = (m_ph + m_step) % 256;
        m_tog  = !m_tog;
      end
      m_sv = en;
      if (app) begin
        m_mode = p_mode; m_step = p_step; m_ph = 0; m_tog = 1;
      end
      m_pend = load || (m_pend && !app);
      if (load) begin
        p_mode = mode; p_step = step;
      end
      m_idle = !en;
    end
  end

  always @(negedge clk) begin
    lit("model wave", wave_out, m_wave);
    lit("model sample_valid", sample_valid, m_sv);
    lit("model period_start", period_start, m_ps);
    lit("model cfg_pending", cfg_pending, m_pend);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg(int m, int s);
    en = 0;
    tick();
    mode = 2'(m); step = 8'(s); load = 1;
    tick();
    load = 0;
    tick();
    en = 1;
  endtask

  task automatic play(string nm, int per);
    for (int i = 0; i < seq.size(); i++) begin
      tick();
      lit({nm, " wave"}, wave_out, seq[i]);
      lit({nm, " period_start"}, period_start, 32'(i % per == 0));
    end
  endtask

  initial begin
    rst = 1; en = 0; load = 0; mode = 0; step = 0;
    #1 rst = 0;
    tick(); tick();
    lit("reset wave", wave_out, 0);
    lit("reset sample_valid", sample_valid, 0);
    lit("reset cfg_pending", cfg_pending, 0);
    rst = 1;
    cfg(0, 1);
    for (int i = 0; i <= 256; i++) begin
      tick();
      lit("saw1 wave", wave_out, i % 256);
      lit("saw1 period_start", period_start, 32'(i % 256 == 0));
    end
    cfg(2, 64);
    seq = '{0, 192, 127, 193, 0, 192, 127, 193};
    play("rhomboid", 4);
    cfg(1, 64);
    seq = '{0, 128, 255, 127, 0, 128};
    play("triangle", 4);
    cfg(3, 128);
    seq = '{0, 255, 0, 255};
    play("square", 2);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("hold wave", wave_out, 255);
      lit("hold sample_valid", sample_valid, 0);
    end
    cfg(0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      lit("switch saw wave", wave_out, i);
    end
    mode = 3; step = 128; load = 1;
    tick();
    load = 0;
    lit("switch pending set", cfg_pending, 1);
    for (int i = 11; i < 256; i++) begin
      tick();
      lit("switch saw tail", wave_out, i);
      lit("switch pending", cfg_pending, 32'(i < 255));
    end
    seq = '{0, 255, 0};
    play("switch square", 2);
    lit("switch pending clear", cfg_pending, 0);
    #2 rst = 0;
    #1;
    lit("midreset wave", wave_out, 0);
    lit("midreset sample_valid", sample_valid, 0);
    lit("midreset period_start", period_start, 0);
    lit("midreset cfg_pending", cfg_pending, 0);
    en = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("post-reset idle", sample_valid, 0);
    end
    en = 1;
    tick();
    lit("restart sample_valid", sample_valid, 1);
    lit("restart wave", wave_out, 0);
    lit("restart period_start", period_start, 1);
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
